// File: rtl/lc3_mem_arbiter.sv
// Arbitrates the single-port LC-3 memory between instruction fetch and the memory-access stage,
// sequencing indirect (pointer-then-data) accesses and producing the pipeline stall enables.
module lc3_mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_valid,
  output logic [DW-1:0] if_data,
  input  logic          ma_req,
  input  logic          ma_we,
  input  logic          ma_ind,
  input  logic [AW-1:0] ma_addr,
  input  logic [DW-1:0] ma_wdata,
  output logic          ma_done,
  output logic [DW-1:0] ma_rdata,
  output logic          stall_if,
  output logic          stall_ma,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  // Handshakes: requesters hold req (and address/data) until their one-cycle done/valid pulse;
  // the memory transfer completes in any cycle with mem_req & mem_ready, and mem_* never
  // change while mem_req is high and mem_ready is low.

  typedef enum logic [1:0] {IDLE, IF_ACC, MA_PTR, MA_ACC} state_t;

  state_t        state, state_d;
  logic          mem_req_d, mem_we_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d, if_data_d, ma_rdata_d;
  logic          if_valid_d, ma_done_d;
  logic          flush_q, flush_d;
  logic          ma_go, if_go;

  // A requester whose completion pulse is showing this cycle is already served.
  assign ma_go    = ma_req & ~ma_done;
  assign if_go    = if_req & ~if_valid & ~if_flush;
  assign stall_if = if_req & ~if_valid & ~if_flush;
  assign stall_ma = ma_req & ~ma_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d     = state;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if_data_d   = if_data;
    ma_rdata_d  = ma_rdata;
    if_valid_d  = 1'b0;
    ma_done_d   = 1'b0;
    flush_d     = flush_q;
    case (state)
      IDLE: begin
        flush_d = 1'b0;
        if (ma_go) begin
          mem_req_d   = 1'b1;
          mem_addr_d  = ma_addr;
          mem_wdata_d = ma_wdata;
          if (ma_ind) begin
            mem_we_d = 1'b0;
            state_d  = MA_PTR;
          end else begin
            mem_we_d = ma_we;
            state_d  = MA_ACC;
          end
        end else if (if_go) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          state_d    = IF_ACC;
        end
      end
      IF_ACC: begin
        if (if_flush) flush_d = 1'b1;
        if (mem_ready) begin
          if_data_d  = mem_rdata;
          if_valid_d = ~(flush_q | if_flush);
          flush_d    = 1'b0;
          mem_req_d  = 1'b0;
          state_d    = IDLE;
        end
      end
      MA_PTR: begin
        // mem_addr doubles as the pointer register; mem_req stays high into the second access.
        if (mem_ready) begin
          mem_addr_d  = AW'(mem_rdata);
          mem_we_d    = ma_we;
          mem_wdata_d = ma_wdata;
          state_d     = MA_ACC;
        end
      end
      MA_ACC: begin
        if (mem_ready) begin
          if (!mem_we) ma_rdata_d = mem_rdata;
          ma_done_d = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_valid  <= 1'b0;
      if_data   <= '0;
      ma_done   <= 1'b0;
      ma_rdata  <= '0;
      flush_q   <= 1'b0;
    end else begin
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      if_valid  <= if_valid_d;
      if_data   <= if_data_d;
      ma_done   <= ma_done_d;
      ma_rdata  <= ma_rdata_d;
      flush_q   <= flush_d;
    end
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter: drivers push expectations into queues, a negedge monitor
// pops and compares on every if_valid, ma_done and completed memory transfer.
module tb_lc3_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, if_flush, if_valid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_data;
  logic          ma_req, ma_we, ma_ind, ma_done;
  logic [AW-1:0] ma_addr;
  logic [DW-1:0] ma_wdata, ma_rdata;
  logic          stall_if, stall_ma;
  logic          mem_req, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  // clock / reset
  always #5 clk = ~clk;

  lc3_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_valid(if_valid), .if_data(if_data),
    .ma_req(ma_req), .ma_we(ma_we), .ma_ind(ma_ind), .ma_addr(ma_addr),
    .ma_wdata(ma_wdata), .ma_done(ma_done), .ma_rdata(ma_rdata),
    .stall_if(stall_if), .stall_ma(stall_ma),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // memory model: wait_cfg wait cycles per transfer, read-only contents
  logic [DW-1:0] mem [0:65535];
  int            wait_cfg;
  int            wcnt;

  assign mem_ready = mem_req && (wcnt >= wait_cfg);
  assign mem_rdata = mem_ready ? mem[mem_addr] : 16'hDEAD;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt <= 0;
    else if (mem_req && mem_ready) wcnt <= 0;
    else if (mem_req) wcnt <= wcnt + 1;
  end

  // scoreboard
  logic [DW-1:0]    if_exp_q[$];
  logic [DW-1:0]    ma_exp_q[$];
  logic [AW:0]      acc_exp_q[$];
  logic [AW+DW-1:0] wr_exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // monitor
  logic          prev_wait = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wdata;
  logic          prev_we;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wait = 1'b0;
    end else begin
      if (if_valid) begin
        if (if_exp_q.size() == 0) chk("if_valid_unexpected", 32'(if_data), 32'hFFFF_FFFF);
        else chk("if_data", 32'(if_data), 32'(if_exp_q.pop_front()));
      end
      if (ma_done) begin
        if (ma_exp_q.size() == 0) chk("ma_done_unexpected", 32'(ma_rdata), 32'hFFFF_FFFF);
        else chk("ma_rdata", 32'(ma_rdata), 32'(ma_exp_q.pop_front()));
      end
      if (prev_wait && mem_req)
        chk("mem_hold", {15'd0, mem_we, mem_addr}, {15'd0, prev_we, prev_addr});
      if (prev_wait && mem_req) chk("mem_hold_wdata", 32'(mem_wdata), 32'(prev_wdata));
      if (mem_req && mem_ready) begin
        if (acc_exp_q.size() == 0) chk("mem_access_unexpected", 32'({mem_we, mem_addr}), 32'hFFFF_FFFF);
        else chk("mem_access", 32'({mem_we, mem_addr}), 32'(acc_exp_q.pop_front()));
        if (mem_we) begin
          if (wr_exp_q.size() == 0) chk("mem_write_unexpected", {mem_addr, mem_wdata}, 32'hFFFF_FFFF);
          else chk("mem_write", {mem_addr, mem_wdata}, wr_exp_q.pop_front());
        end
      end
      prev_wait  = mem_req && !mem_ready;
      prev_addr  = mem_addr;
      prev_we    = mem_we;
      prev_wdata = mem_wdata;
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [AW-1:0] addr, input logic [DW-1:0] data, input int exp_lat);
    int lat;
    lat = -1;
    if_exp_q.push_back(data);
    if_req  = 1'b1;
    if_addr = addr;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (if_valid) begin
        lat = n;
        chk("stall_if_at_valid", 32'(stall_if), 32'd0);
        break;
      end
      if (n == 0) chk("stall_if_c0", 32'(stall_if), 32'd1);
    end
    chk("if_latency", 32'(lat), 32'(exp_lat));
    cyc(1);
    if_req = 1'b0;
  endtask

  task automatic ma_op(input logic we, input logic ind, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata,
                       input int exp_lat);
    int lat;
    lat = -1;
    ma_exp_q.push_back(exp_rdata);
    ma_req   = 1'b1;
    ma_we    = we;
    ma_ind   = ind;
    ma_addr  = addr;
    ma_wdata = wdata;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (ma_done) begin
        lat = n;
        chk("stall_ma_at_done", 32'(stall_ma), 32'd0);
        break;
      end
      if (n == 0) chk("stall_ma_c0", 32'(stall_ma), 32'd1);
    end
    chk("ma_latency", 32'(lat), 32'(exp_lat));
    cyc(1);
    ma_req = 1'b0;
    ma_we  = 1'b0;
    ma_ind = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"},   32'(mem_req),   32'd0);
    chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_if_valid"},  32'(if_valid),  32'd0);
    chk({tag, "_if_data"},   32'(if_data),   32'd0);
    chk({tag, "_ma_done"},   32'(ma_done),   32'd0);
    chk({tag, "_ma_rdata"},  32'(ma_rdata),  32'd0);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    ma_req = 1'b0; ma_we = 1'b0; ma_ind = 1'b0; ma_addr = '0; ma_wdata = '0;
    wait_cfg = 0;
    mem[16'h3000] = 16'h1234; mem[16'h3001] = 16'h2222; mem[16'h3002] = 16'h3333;
    mem[16'h3003] = 16'h5A5A; mem[16'h3004] = 16'h4444;
    mem[16'h4000] = 16'h5000; mem[16'h5000] = 16'hBEEF;
    mem[16'h4100] = 16'h0000;
    cyc(3);
    @(negedge clk);
    chk_all_zero("reset");
    cyc(1);
    rst_n = 1'b1;
    cyc(2);

    // 1: fetch alone, valid two cycles after the request cycle
    acc_exp_q.push_back({1'b0, 16'h3000});
    fetch(16'h3000, 16'h1234, 2);
    cyc(2);

    // 2: simultaneous LDR and fetch; load first, fetch granted in the ma_done cycle -> valid in C4
    acc_exp_q.push_back({1'b0, 16'h4000});
    acc_exp_q.push_back({1'b0, 16'h3001});
    fork
      ma_op(1'b0, 1'b0, 16'h4000, 16'h0000, 16'h5000, 2);
      fetch(16'h3001, 16'h2222, 4);
    join
    cyc(2);

    // 3: LDI, pointer then data back-to-back
    acc_exp_q.push_back({1'b0, 16'h4000});
    acc_exp_q.push_back({1'b0, 16'h5000});
    ma_op(1'b0, 1'b1, 16'h4000, 16'h0000, 16'hBEEF, 3);
    cyc(2);

    // 4: STI with 3 wait cycles per access; ma_rdata keeps the last load value
    wait_cfg = 3;
    acc_exp_q.push_back({1'b0, 16'h4000});
    acc_exp_q.push_back({1'b1, 16'h5000});
    wr_exp_q.push_back({16'h5000, 16'hA5A5});
    ma_op(1'b1, 1'b1, 16'h4000, 16'hA5A5, 16'hBEEF, 9);
    cyc(2);

    // 5: flush during a delayed fetch; transfer completes silently, next fetch is normal
    wait_cfg = 2;
    acc_exp_q.push_back({1'b0, 16'h3002});
    if_req = 1'b1; if_addr = 16'h3002;
    cyc(2);
    if_flush = 1'b1; if_req = 1'b0;
    cnt = 0;
    @(negedge clk);
    chk("stall_if_flush", 32'(stall_if), 32'd0);
    if (if_valid) cnt++;
    cyc(1);
    if_flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (if_valid) cnt++;
    end
    chk("flush_no_valid", 32'(cnt), 32'd0);
    chk("flush_mem_idle", 32'(mem_req), 32'd0);
    cyc(1);
    wait_cfg = 0;
    acc_exp_q.push_back({1'b0, 16'h3003});
    fetch(16'h3003, 16'h5A5A, 2);
    cyc(2);

    // 6: reset while a store waits in MA_ACC
    wait_cfg = 5;
    ma_req = 1'b1; ma_we = 1'b1; ma_ind = 1'b0; ma_addr = 16'h4100; ma_wdata = 16'h1111;
    cyc(2);
    @(negedge clk);
    chk("pre_reset_mem_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_mem_req", 32'(mem_req), 32'd0);
    chk("async_reset_ma_done", 32'(ma_done), 32'd0);
    cyc(1);
    ma_req = 1'b0; ma_we = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    wait_cfg = 0;
    @(negedge clk);
    chk_all_zero("post_reset");
    cyc(3);
    acc_exp_q.push_back({1'b0, 16'h3004});
    fetch(16'h3004, 16'h4444, 2);
    cyc(3);

    chk("if_q_empty",  32'(if_exp_q.size()),  32'd0);
    chk("ma_q_empty",  32'(ma_exp_q.size()),  32'd0);
    chk("acc_q_empty", 32'(acc_exp_q.size()), 32'd0);
    chk("wr_q_empty",  32'(wr_exp_q.size()),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
